// File: rtl/instr_fetch_ctrl.sv
// Purpose: PC sequencer for a combinational instruction memory, with a one-entry valid/ready slot towards decode.
// Latency: if_valid rises one edge after imem_addr is presented; a redirect target is valid two edges after br_taken.
// Backpressure: slot, pc and fetch hold while if_valid & !if_ready; a redirect flushes the slot regardless of if_ready.
module instr_fetch_ctrl #(
  parameter int N        = 32,
  parameter int M        = 256,
  parameter int START_PC = 0
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_data,
  output logic         if_valid,
  input  logic         if_ready,
  output logic [N-1:0] if_instr,
  output logic [N-1:0] if_pc,
  input  logic         br_taken,
  input  logic [N-1:0] br_base,
  input  logic [N-1:0] br_offset,
  output logic         halt,
  output logic [N-1:0] fetch_cnt
);

  localparam logic [N-1:0] PC_RST  = N'(START_PC);
  localparam logic [N-1:0] PC_LAST = N'(M - 1);
  // One bit wider so a depth of exactly 2^N still compares correctly.
  localparam logic [N:0]   DEPTH   = (N+1)'(M);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [N-1:0] pc, pc_nxt;
  logic         if_valid_nxt;
  logic [N-1:0] if_instr_nxt, if_pc_nxt, fetch_cnt_nxt;
  logic         slot_free, hs, redirect, tgt_ok;
  logic [N-1:0] tgt;

  assign slot_free = !if_valid || if_ready;
  assign hs        = if_valid && if_ready;
  // Execute may pulse br_taken during the idle cycle after reset; it is dropped there.
  assign redirect  = br_taken && (state != BOOT);
  // Offset counts instructions and pc is a word index, so no scaling; wraps in N bits.
  assign tgt       = br_base + br_offset;
  assign tgt_ok    = {1'b0, tgt} < DEPTH;
  assign imem_addr = pc;
  assign halt      = (state == HALT);

  // State, pc, output slot and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= PC_RST;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      if_valid  <= if_valid_nxt;
      if_instr  <= if_instr_nxt;
      if_pc     <= if_pc_nxt;
      fetch_cnt <= fetch_cnt_nxt;
    end
  end

  // Next-state logic: redirect beats sequential fetch; halt on the last word or an out-of-range target.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    if_valid_nxt  = if_valid;
    if_instr_nxt  = if_instr;
    if_pc_nxt     = if_pc;
    fetch_cnt_nxt = fetch_cnt;

    // Handshakes count in every state, including the cycle a redirect flushes the slot.
    if (hs && (fetch_cnt != '1)) begin
      fetch_cnt_nxt = fetch_cnt + N'(1);
    end

    case (state)
      BOOT: begin
        state_nxt = FETCH;
      end
      FETCH, HALT: begin
        if (redirect) begin
          if_valid_nxt = 1'b0;
          if (tgt_ok) begin
            pc_nxt    = tgt;
            state_nxt = FETCH;
          end else begin
            state_nxt = HALT;
          end
        end else if (state == FETCH) begin
          if (slot_free) begin
            if_instr_nxt = imem_data;
            if_pc_nxt    = pc;
            if_valid_nxt = 1'b1;
            pc_nxt       = pc + N'(1);
            if (pc == PC_LAST) begin
              state_nxt = HALT;
            end
          end
        end else if (hs) begin
          // Halted: the last word stays until decode takes it.
          if_valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_ready, br_taken;
  logic [31:0] br_base, br_offset;

  // Main instance: N=32, M=256
  logic [31:0] a_addr, a_data, a_instr, a_pc, a_cnt;
  logic        a_valid, a_halt;
  // Short-memory instance: N=32, M=8
  logic [31:0] b_addr, b_data, b_instr, b_pc, b_cnt;
  logic        b_valid, b_halt;
  // Narrow instance: N=4, M=8, lets the counter reach saturation
  logic [3:0]  c_addr, c_data, c_instr, c_pc, c_cnt;
  logic        c_valid, c_halt;

  // Memory word k holds k+100 (truncated to the instance width)
  assign a_data = a_addr + 32'd100;
  assign b_data = b_addr + 32'd100;
  assign c_data = c_addr + 4'd4;

  instr_fetch_ctrl #(.N(32), .M(256), .START_PC(0)) dut (
    .clk(clk), .rst(rst), .imem_addr(a_addr), .imem_data(a_data),
    .if_valid(a_valid), .if_ready(if_ready), .if_instr(a_instr), .if_pc(a_pc),
    .br_taken(br_taken), .br_base(br_base), .br_offset(br_offset),
    .halt(a_halt), .fetch_cnt(a_cnt));

  instr_fetch_ctrl #(.N(32), .M(8), .START_PC(0)) dut_m8 (
    .clk(clk), .rst(rst), .imem_addr(b_addr), .imem_data(b_data),
    .if_valid(b_valid), .if_ready(if_ready), .if_instr(b_instr), .if_pc(b_pc),
    .br_taken(br_taken), .br_base(br_base), .br_offset(br_offset),
    .halt(b_halt), .fetch_cnt(b_cnt));

  instr_fetch_ctrl #(.N(4), .M(8), .START_PC(0)) dut_n4 (
    .clk(clk), .rst(rst), .imem_addr(c_addr), .imem_data(c_data),
    .if_valid(c_valid), .if_ready(if_ready), .if_instr(c_instr), .if_pc(c_pc),
    .br_taken(br_taken), .br_base(br_base[3:0]), .br_offset(br_offset[3:0]),
    .halt(c_halt), .fetch_cnt(c_cnt));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed vector table for the M=256 instance
  typedef struct {
    logic        rst, rdy, br;
    logic [31:0] base, off;
    logic        v;
    logic [31:0] ipc, instr, addr, cnt;
    logic        h;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic r, input logic rd, input logic b, input logic [31:0] bs,
                     input logic [31:0] of, input logic v, input logic [31:0] ip,
                     input logic [31:0] ins, input logic [31:0] ad, input logic [31:0] cn,
                     input logic h);
    vec_t x;
    x.rst = r; x.rdy = rd; x.br = b; x.base = bs; x.off = of;
    x.v = v; x.ipc = ip; x.instr = ins; x.addr = ad; x.cnt = cn; x.h = h;
    vt.push_back(x);
  endtask

  // Behavioural reference: three instances, indexed 0 (M=256), 1 (M=8), 2 (N=4,M=8)
  logic [31:0] m_pc[3], m_ipc[3], m_instr[3], m_cnt[3];
  bit          m_v[3], m_boot[3], m_halt[3];
  int          m_depth[3] = '{256, 8, 8};
  logic [31:0] m_mask[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};

  task automatic model_step(input int k);
    logic [31:0] msk, tgt;
    msk = m_mask[k];
    if (rst) begin
      m_pc[k] = 0; m_ipc[k] = 0; m_instr[k] = 0; m_cnt[k] = 0;
      m_v[k] = 0; m_boot[k] = 1; m_halt[k] = 0;
      return;
    end
    if (m_v[k] && if_ready && m_cnt[k] != msk) m_cnt[k] = m_cnt[k] + 1;
    if (m_boot[k]) begin
      m_boot[k] = 0;
      return;
    end
    if (br_taken) begin
      tgt = (br_base + br_offset) & msk;
      m_v[k] = 0;
      if (tgt < 32'(m_depth[k])) begin
        m_pc[k] = tgt;
        m_halt[k] = 0;
      end else begin
        m_halt[k] = 1;
      end
    end else if (!m_halt[k] && (!m_v[k] || if_ready)) begin
      m_ipc[k]   = m_pc[k];
      m_instr[k] = (m_pc[k] + 100) & msk;
      m_v[k]     = 1;
      m_pc[k]    = m_pc[k] + 1;
      if (m_pc[k] == 32'(m_depth[k])) m_halt[k] = 1;
    end else if (m_v[k] && if_ready) begin
      m_v[k] = 0;
    end
  endtask

  task automatic cmp_model(input int k, input int cyc);
    logic [31:0] av, ah, aa, ac, ap, ai;
    case (k)
      0: begin av = {31'b0, a_valid}; ah = {31'b0, a_halt}; aa = a_addr; ac = a_cnt; ap = a_pc; ai = a_instr; end
      1: begin av = {31'b0, b_valid}; ah = {31'b0, b_halt}; aa = b_addr; ac = b_cnt; ap = b_pc; ai = b_instr; end
      default: begin
        av = {31'b0, c_valid}; ah = {31'b0, c_halt}; aa = {28'b0, c_addr};
        ac = {28'b0, c_cnt}; ap = {28'b0, c_pc}; ai = {28'b0, c_instr};
      end
    endcase
    chk($sformatf("rnd%0d_i%0d_valid", cyc, k), av, {31'b0, m_v[k]});
    chk($sformatf("rnd%0d_i%0d_halt", cyc, k), ah, {31'b0, (m_halt[k] && !m_boot[k])});
    chk($sformatf("rnd%0d_i%0d_addr", cyc, k), aa, m_pc[k]);
    chk($sformatf("rnd%0d_i%0d_cnt", cyc, k), ac, m_cnt[k]);
    if (m_v[k]) begin
      chk($sformatf("rnd%0d_i%0d_pc", cyc, k), ap, m_ipc[k]);
      chk($sformatf("rnd%0d_i%0d_instr", cyc, k), ai, m_instr[k]);
    end
  endtask

  task automatic chk_b(input string nm, input logic v, input logic [31:0] ipc,
                       input logic h, input logic [31:0] ad);
    chk({nm, "_valid"}, {31'b0, b_valid}, {31'b0, v});
    chk({nm, "_halt"}, {31'b0, b_halt}, {31'b0, h});
    chk({nm, "_addr"}, b_addr, ad);
    if (v) begin
      chk({nm, "_pc"}, b_pc, ipc);
      chk({nm, "_instr"}, b_instr, ipc + 32'd100);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_ready = 1'b1; br_taken = 1'b0; br_base = '0; br_offset = '0;

    // rst rdy br base off | valid if_pc instr addr cnt halt
    add(1,1,0, 0, 0,            0, 0, 0,   0, 0, 0); // reset state
    add(0,1,0, 0, 0,            0, 0, 0,   0, 0, 0); // BOOT cycle
    add(0,1,0, 0, 0,            1, 0, 100, 1, 0, 0); // first valid, 2nd edge
    add(0,1,0, 0, 0,            1, 1, 101, 2, 1, 0);
    add(0,1,0, 0, 0,            1, 2, 102, 3, 2, 0);
    add(0,0,0, 0, 0,            1, 2, 102, 3, 2, 0); // stall x3
    add(0,0,0, 0, 0,            1, 2, 102, 3, 2, 0);
    add(0,0,0, 0, 0,            1, 2, 102, 3, 2, 0);
    add(0,1,0, 0, 0,            1, 3, 103, 4, 3, 0); // resumes without skip
    add(0,1,0, 0, 0,            1, 4, 104, 5, 4, 0);
    add(0,1,1, 4, 2,            0, 0, 0,   6, 5, 0); // redirect +2, flush, handshake counted
    add(0,1,0, 0, 0,            1, 6, 106, 7, 5, 0);
    add(0,1,0, 0, 0,            1, 7, 107, 8, 6, 0);
    add(1,1,0, 0, 0,            0, 0, 0,   0, 0, 0); // reset while valid
    add(0,1,1, 50, 0,           0, 0, 0,   0, 0, 0); // redirect ignored in BOOT
    add(0,1,0, 0, 0,            1, 0, 100, 1, 0, 0);
    add(0,1,1, 5, 300,          0, 0, 0,   1, 1, 1); // target 305 out of range
    add(0,1,0, 0, 0,            0, 0, 0,   1, 1, 1);
    add(0,1,1, 0, 32'hFFFF_FFFF,0, 0, 0,   1, 1, 1); // negative wrap stays halted
    add(0,1,1, 10, 32'hFFFF_FFFD,0,0, 0,   7, 1, 0); // resume from HALT at 7
    add(0,1,0, 0, 0,            1, 7, 107, 8, 1, 0);
    add(0,1,0, 0, 0,            1, 8, 108, 9, 2, 0);

    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; if_ready = vt[i].rdy; br_taken = vt[i].br;
      br_base = vt[i].base; br_offset = vt[i].off;
      step();
      chk($sformatf("vec%0d_valid", i), {31'b0, a_valid}, {31'b0, vt[i].v});
      chk($sformatf("vec%0d_halt", i), {31'b0, a_halt}, {31'b0, vt[i].h});
      chk($sformatf("vec%0d_addr", i), a_addr, vt[i].addr);
      chk($sformatf("vec%0d_cnt", i), a_cnt, vt[i].cnt);
      if (vt[i].v || vt[i].rst) begin
        chk($sformatf("vec%0d_pc", i), a_pc, vt[i].ipc);
        chk($sformatf("vec%0d_instr", i), a_instr, vt[i].instr);
      end
    end
    br_taken = 1'b0; br_base = '0; br_offset = '0;

    // M=8 run-through: halt after the last word, hold it under backpressure, then resume
    rst = 1'b1; if_ready = 1'b1; step();
    rst = 1'b0; step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk_b($sformatf("m8_run%0d", i), 1'b1, 32'(i), (i == 7), 32'(i + 1));
    end
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_b($sformatf("m8_hold%0d", i), 1'b1, 32'd7, 1'b1, 32'd8);
    end
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_b($sformatf("m8_idle%0d", i), 1'b0, 32'd0, 1'b1, 32'd8);
    end
    chk("m8_cnt_end", b_cnt, 32'd8);
    br_taken = 1'b1; br_base = 32'd7; br_offset = 32'hFFFF_FFF9;
    step();
    br_taken = 1'b0;
    chk_b("m8_redir", 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk_b($sformatf("m8_rerun%0d", i), 1'b1, 32'(i), (i == 7), 32'(i + 1));
    end
    step();
    chk_b("m8_halt2", 1'b0, 32'd0, 1'b1, 32'd8);
    chk("m8_cnt_end2", b_cnt, 32'd16);
    rst = 1'b1; step();
    chk_b("m8_rst_halt", 1'b0, 32'd0, 1'b0, 32'd0);
    chk("m8_rst_cnt", b_cnt, 32'd0);
    chk("m8_rst_pc", b_pc, 32'd0);
    chk("m8_rst_instr", b_instr, 32'd0);
    rst = 1'b0; step();
    chk_b("m8_boot", 1'b0, 32'd0, 1'b0, 32'd0);
    step();
    chk_b("m8_restart", 1'b1, 32'd0, 1'b0, 32'd1);

    // Randomized run on all three instances against the reference model
    rst = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) begin
        rst      = ($urandom_range(0, 199) == 0);
        if_ready = ($urandom_range(0, 3) != 0);
        br_taken = ($urandom_range(0, 7) == 0);
        br_base  = 32'($urandom_range(0, 12));
        case ($urandom_range(0, 9))
          0:       br_offset = 32'd300;
          1:       br_offset = $urandom;
          default: br_offset = 32'($urandom_range(0, 16)) - 32'd8;
        endcase
      end
      for (int k = 0; k < 3; k++) model_step(k);
      step();
      for (int k = 0; k < 3; k++) cmp_model(k, cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
